// File: rtl/despachante_pkg.sv
// rtl/despachante_pkg.sv - shared slot state encodings and width helper for the terminal dispatcher
package despachante_pkg;

  typedef enum logic [1:0] {
    ST_FREE = 2'b00,
    ST_BUSY = 2'b01,
    ST_OFF  = 2'b10
  } slot_state_t;

  // Smallest r such that 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/terminal_slot.sv
// rtl/terminal_slot.sv - one terminal: FREE/BUSY/OFF state machine with dwell counter
module terminal_slot
  import despachante_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DWELL = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic enable,
  input  logic release_strobe,
  output logic free_eligible,
  output logic busy
);

  // Counter holds remaining cycles minus one, so BUSY lasts exactly DWELL cycles.
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

  slot_state_t      state;
  logic [CNT_W-1:0] cnt;

  // Eligibility looks only at registered state, so a slot leaving BUSY waits a cycle.
  assign free_eligible = (state == ST_FREE) && enable;
  assign busy          = (state == ST_BUSY);

  // Slot state machine; an occupancy always runs to its end regardless of enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FREE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_FREE: begin
          if (grant) begin
            state <= ST_BUSY;
            cnt   <= DWELL_LOAD;
          end else if (!enable) begin
            state <= ST_OFF;
          end
        end
        ST_BUSY: begin
          if ((cnt == '0) || release_strobe) begin
            state <= enable ? ST_FREE : ST_OFF;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_OFF: begin
          if (enable) state <= ST_FREE;
        end
        default: state <= ST_FREE;
      endcase
    end
  end

endmodule

// File: rtl/despachante_terminais.sv
// rtl/despachante_terminais.sv - round-robin dispatcher assigning arrivals to free terminals
module despachante_terminais
  import despachante_pkg::*;
#(
  parameter  int N_TERM = 2,
  parameter  int CNT_W  = 8,
  parameter  int DWELL  = 10,
  localparam int ID_W   = (clog2(N_TERM) < 1) ? 1 : clog2(N_TERM)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  output logic              READY,
  input  logic [N_TERM-1:0] ENABLE,
  input  logic [N_TERM-1:0] RELEASE,
  output logic              GRANT_VALID,
  output logic [ID_W-1:0]   GRANT_ID,
  output logic [N_TERM-1:0] TERMINAL,
  output logic [N_TERM-1:0] BUSY,
  output logic              FULL,
  output logic [CNT_W-1:0]  SERVED
);

  logic [N_TERM-1:0] eligible;
  logic [N_TERM-1:0] grant_vec;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic              winner_found;
  logic              accept;
  int                idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_TERM; gi++) begin : g_slot
      terminal_slot #(
        .CNT_W(CNT_W),
        .DWELL(DWELL)
      ) u_slot (
        .clk           (CLK),
        .rst           (RST),
        .grant         (grant_vec[gi]),
        .enable        (ENABLE[gi]),
        .release_strobe(RELEASE[gi]),
        .free_eligible (eligible[gi]),
        .busy          (BUSY[gi])
      );
    end
  endgenerate

  assign READY  = |eligible;
  assign FULL   = ~READY;
  assign accept = REQ & READY;

  // Round-robin search: first eligible slot at or after the pointer, wrapping.
  always_comb begin
    winner_found = 1'b0;
    winner       = '0;
    idx          = 0;
    for (int k = 0; k < N_TERM; k++) begin
      idx = (int'(ptr) + k) % N_TERM;
      if (!winner_found && eligible[idx]) begin
        winner_found = 1'b1;
        winner       = ID_W'(idx);
      end
    end
  end

  // One-hot grant to the winning slot, only on an accepted request.
  always_comb begin
    grant_vec = '0;
    if (accept) grant_vec[winner] = 1'b1;
  end

  // Grant registers, pointer advance and served counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr         <= '0;
      GRANT_VALID <= 1'b0;
      GRANT_ID    <= '0;
      TERMINAL    <= '0;
      SERVED      <= '0;
    end else begin
      GRANT_VALID <= accept;
      GRANT_ID    <= accept ? winner : '0;
      TERMINAL    <= grant_vec;
      if (accept) begin
        ptr    <= (int'(winner) == N_TERM - 1) ? '0 : winner + 1'b1;
        SERVED <= SERVED + 1'b1;
      end
    end
  end

endmodule
